// File: rtl/guess_limit_fsm.sv
// Guess-budget controller: registered IDLE/PLAY/WON/LOST game FSM with guess counting and warning.
// Optional best-score tracking is enabled by defining GUESS_LIMIT_BEST_SCORE_EN.
module guess_limit_fsm #(
    parameter int WIDTH       = 8,
    parameter int MAX_GUESSES = 10,
    parameter int WARN_LEFT   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             guess,
    input  logic             correct,
    output logic [WIDTH-1:0] guessCount,
    output logic [WIDTH-1:0] remaining,
    output logic             play,
    output logic             gameOver,
    output logic             won,
    output logic             lost,
    output logic             warn,
`ifdef GUESS_LIMIT_BEST_SCORE_EN
    output logic [WIDTH-1:0] bestScore,
    output logic             bestValid,
`endif
    output logic [1:0]       o_state
);

    // Handshake: start/guess are single-cycle strobes with no back-pressure;
    // a strobe is consumed on the rising clk edge where it is high, and
    // correct is only looked at when guess is high in PLAY.

    generate
        if (MAX_GUESSES < 1 || MAX_GUESSES >= 2**WIDTH) begin : g_bad_max
            $error("guess_limit_fsm: MAX_GUESSES out of range for WIDTH");
        end
        if (WARN_LEFT < 0 || WARN_LEFT >= MAX_GUESSES) begin : g_bad_warn
            $error("guess_limit_fsm: WARN_LEFT must be below MAX_GUESSES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_GUESSES);
    localparam logic [WIDTH-1:0] WARN_W = WIDTH'(WARN_LEFT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + WIDTH'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Start wins over a same-cycle guess; a win on the last allowed guess beats the limit.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_count_nxt = '0;
                end
            end
            S_PLAY: begin
                if (start) begin
                    w_count_nxt = '0;
                end else if (guess) begin
                    w_count_nxt = w_count_inc;
                    if (correct) begin
                        w_state_nxt = S_WON;
                    end else if (w_count_inc == MAX_W) begin
                        w_state_nxt = S_LOST;
                    end
                end
            end
            S_WON, S_LOST: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign guessCount = r_count;
    assign remaining  = MAX_W - r_count;
    assign play       = (r_state == S_PLAY);
    assign won        = (r_state == S_WON);
    assign lost       = (r_state == S_LOST);
    assign gameOver   = won | lost;
    assign warn       = play && (remaining <= WARN_W);
    assign o_state    = r_state;

`ifdef GUESS_LIMIT_BEST_SCORE_EN
    logic [WIDTH-1:0] r_best;
    logic             r_best_valid;
    logic             w_win_entry;

    assign w_win_entry = (r_state == S_PLAY) && (w_state_nxt == S_WON);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best       <= '0;
            r_best_valid <= 1'b0;
        end else if (w_win_entry && (!r_best_valid || (w_count_nxt < r_best))) begin
            r_best       <= w_count_nxt;
            r_best_valid <= 1'b1;
        end
    end

    assign bestScore = r_best;
    assign bestValid = r_best_valid;
`endif

endmodule
